// File: rtl/pwm_burst_gen.sv
// PWM burst engine in the slave clock domain: started by the synchronizer's enable pulse,
// emits num x period PWM ticks, then pulses o_done. Define PWM_BURST_RETRIG_EN for restart-in-RUN.
module pwm_burst_gen #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned NUM_W = 8
) (
   input  logic             i_sclk,
   input  logic             i_rst_n,
   input  logic             i_ena,
   input  logic             i_sen,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_period,
   input  logic [CNT_W-1:0] i_duty,
   input  logic [NUM_W-1:0] i_num,
   output logic             o_pwm,
   output logic             o_busy,
   output logic             o_done,
   output logic [NUM_W-1:0] o_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   tick_q, tick_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   duty_q, duty_d;
   logic [NUM_W-1:0]   num_q, num_d;
   logic [NUM_W-1:0]   cnt_q, cnt_d;

   logic               start_ok;
   logic               last_tick;
   logic [NUM_W-1:0]   cnt_inc;
   logic               final_wrap;

   assign start_ok   = (i_period != '0) && (i_num != '0);
   assign last_tick  = (tick_q == period_q - CNT_W'(1));
   assign cnt_inc    = cnt_q + NUM_W'(1);
   assign final_wrap = i_ena && last_tick && (cnt_inc == num_q);

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      period_d = period_q;
      duty_d   = duty_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (i_sen) begin
               period_d = i_period;
               duty_d   = i_duty;
               num_d    = i_num;
               tick_d   = '0;
               cnt_d    = '0;
               state_d  = start_ok ? StRun : StDone;
            end
         end
         StRun: begin
            if (i_abort) begin
               // A completion landing on the abort edge is still counted.
               state_d = StDone;
               if (final_wrap) begin
                  tick_d = '0;
                  cnt_d  = cnt_inc;
               end
`ifdef PWM_BURST_RETRIG_EN
            end else if (i_sen) begin
               period_d = i_period;
               duty_d   = i_duty;
               num_d    = i_num;
               tick_d   = '0;
               cnt_d    = '0;
               state_d  = start_ok ? StRun : StDone;
`endif
            end else if (i_ena) begin
               if (last_tick) begin
                  tick_d = '0;
                  cnt_d  = cnt_inc;
                  if (cnt_inc == num_q) begin
                     state_d = StDone;
                  end
               end else begin
                  tick_d = tick_q + CNT_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_sclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         tick_q   <= '0;
         period_q <= '0;
         duty_q   <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         num_q    <= num_d;
         cnt_q    <= cnt_d;
      end
   end

   // Outputs decode registered state only, so no input reaches them combinationally.
   assign o_busy = (state_q == StRun);
   assign o_done = (state_q == StDone);
   assign o_pwm  = (state_q == StRun) && (tick_q < duty_q);
   assign o_cnt  = cnt_q;

endmodule

// File: tb/tb_pwm_burst_gen.sv
// Randomized scoreboard bench for pwm_burst_gen: stimulus pushes the burst summary predicted
// from period/duty/num arithmetic; a negedge monitor checks every cycle and pops on o_done.
module tb_pwm_burst_gen;

   localparam int CNT_W = 16;
   localparam int NUM_W = 8;
`ifdef PWM_BURST_RETRIG_EN
   localparam bit SenInRun = 1'b0;
`else
   localparam bit SenInRun = 1'b1;
`endif

   logic             i_sclk;
   logic             i_rst_n;
   logic             i_ena;
   logic             i_sen;
   logic             i_abort;
   logic [CNT_W-1:0] i_period;
   logic [CNT_W-1:0] i_duty;
   logic [NUM_W-1:0] i_num;
   logic             o_pwm;
   logic             o_busy;
   logic             o_done;
   logic [NUM_W-1:0] o_cnt;

   pwm_burst_gen #(
      .CNT_W(CNT_W),
      .NUM_W(NUM_W)
   ) dut (
      .i_sclk  (i_sclk),
      .i_rst_n (i_rst_n),
      .i_ena   (i_ena),
      .i_sen   (i_sen),
      .i_abort (i_abort),
      .i_period(i_period),
      .i_duty  (i_duty),
      .i_num   (i_num),
      .o_pwm   (o_pwm),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_cnt   (o_cnt)
   );

   initial i_sclk = 1'b0;
   always #5 i_sclk = ~i_sclk;

   typedef struct {
      int per;
      int duty;
      int cnt;
      int ticks;
      int pwm_ticks;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   mon_ticks = 0;
   int   mon_pwm = 0;
   bit   prev_done = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Expected summary of a burst that ran for t ena-ticks.
   function automatic exp_t predict(input int per, input int duty, input int t);
      exp_t e;
      e.per       = per;
      e.duty      = duty;
      e.ticks     = t;
      e.cnt       = (per == 0) ? 0 : t / per;
      e.pwm_ticks = (per == 0) ? 0 : (t / per) * imin(duty, per) + imin(duty, t % per);
      return e;
   endfunction

   // Monitor: per-cycle waveform from tick index arithmetic, burst summary on o_done.
   always @(negedge i_sclk) begin
      if (!i_rst_n) begin
         mon_ticks = 0;
         mon_pwm   = 0;
         prev_done = 1'b0;
      end else begin
         if (o_busy) begin
            check("busy_has_txn", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cur = exp_q[0];
               if (cur.per == 0) cur.per = 1;
               check("pwm", o_pwm, (mon_ticks % cur.per) < cur.duty);
               check("cnt_run", o_cnt, mon_ticks / cur.per);
               check("done_in_run", o_done, 0);
            end
            if (i_ena) begin
               mon_ticks++;
               if (o_pwm) mon_pwm++;
            end
`ifdef PWM_BURST_RETRIG_EN
            if (i_sen && !i_abort) begin
               mon_ticks = 0;
               mon_pwm   = 0;
            end
`endif
         end else begin
            check("pwm_not_busy", o_pwm, 0);
         end
         if (o_done) begin
            check("done_width", prev_done, 0);
            check("done_has_txn", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               check("done_cnt", o_cnt, cur.cnt);
               check("done_ticks", mon_ticks, cur.ticks);
               check("done_pwm_ticks", mon_pwm, cur.pwm_ticks);
            end
            mon_ticks = 0;
            mon_pwm   = 0;
         end
         prev_done = o_done;
      end
   end

   task automatic randomize_cfg();
      i_period = CNT_W'($urandom_range(0, 9));
      i_duty   = CNT_W'($urandom_range(0, 9));
      i_num    = NUM_W'($urandom_range(0, 5));
   endtask

   // ena_mode: 0 always, 1 every second cycle, 2 random.
   task automatic run_burst(input int per, input int duty, input int num, input int ena_mode,
                            input int abort_at, input bit final_abort, input bit sen_in_run);
      int   total;
      int   ticks;
      int   cyc;
      int   budget;
      bit   en;
      bit   aborted;
      exp_t e;
      total   = per * num;
      budget  = 4 * total + 20;
      aborted = 1'b0;
      if (total == 0)        e = predict(per, duty, 0);
      else if (abort_at < 0) e = predict(per, duty, total);
      else if (final_abort)  e = predict(per, duty, total);
      else                   e = predict(per, duty, abort_at);

      @(posedge i_sclk); #1;
      i_period = CNT_W'(per);
      i_duty   = CNT_W'(duty);
      i_num    = NUM_W'(num);
      i_sen    = 1'b1;
      i_abort  = 1'($urandom_range(0, 1));
      i_ena    = 1'($urandom_range(0, 1));
      exp_q.push_back(e);
      @(posedge i_sclk); #1;
      i_sen   = 1'b0;
      i_abort = 1'b0;
      randomize_cfg();
      if (total != 0) begin
         ticks = 0;
         cyc   = 0;
         while (ticks < total && cyc < budget && !aborted) begin
            case (ena_mode)
               0:       en = 1'b1;
               1:       en = (cyc % 2) == 1;
               default: en = 1'($urandom_range(0, 1));
            endcase
            i_abort = 1'b0;
            if (abort_at >= 0 && ticks == abort_at) begin
               i_abort = 1'b1;
               en      = final_abort;
               aborted = 1'b1;
            end
            i_ena = en;
            i_sen = sen_in_run && (cyc == 1);
            @(posedge i_sclk); #1;
            cyc++;
            if (en) ticks++;
            randomize_cfg();
         end
         check("burst_in_budget", (ticks >= total) || aborted, 1);
      end
      i_abort = 1'b0;
      i_sen   = 1'b0;
      i_ena   = 1'b0;
      repeat (3) @(posedge i_sclk);
      #1;
      i_ena = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int per;
      int duty;
      int num;
      int abort_at;
      bit fin;
      i_rst_n  = 1'b0;
      i_ena    = 1'b0;
      i_sen    = 1'b0;
      i_abort  = 1'b0;
      i_period = '0;
      i_duty   = '0;
      i_num    = '0;
      repeat (3) @(posedge i_sclk);
      #1;
      check("rst_pwm", o_pwm, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_cnt", o_cnt, 0);
      i_rst_n = 1'b1;

      run_burst(4, 1, 3, 0, -1, 1'b0, 1'b0);
      run_burst(3, 2, 2, 1, -1, 1'b0, 1'b0);
      run_burst(5, 0, 2, 2, -1, 1'b0, 1'b0);
      run_burst(4, 5, 2, 0, -1, 1'b0, 1'b0);
      run_burst(0, 3, 3, 0, -1, 1'b0, 1'b0);
      run_burst(4, 2, 0, 0, -1, 1'b0, 1'b0);
      run_burst(8, 3, 4, 0, 13, 1'b0, SenInRun);
      run_burst(3, 1, 2, 2, 5, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a burst.
      @(posedge i_sclk); #1;
      i_period = CNT_W'(4);
      i_duty   = CNT_W'(3);
      i_num    = NUM_W'(5);
      i_sen    = 1'b1;
      exp_q.push_back(predict(4, 3, 20));
      @(posedge i_sclk); #1;
      i_sen = 1'b0;
      i_ena = 1'b1;
      repeat (6) @(posedge i_sclk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_pwm", o_pwm, 0);
      check("arst_busy", o_busy, 0);
      check("arst_done", o_done, 0);
      check("arst_cnt", o_cnt, 0);
      exp_q.delete();
      @(negedge i_sclk);
      @(posedge i_sclk); #1;
      i_rst_n = 1'b1;
      i_ena   = 1'b0;
      run_burst(4, 3, 2, 0, -1, 1'b0, 1'b0);

`ifdef PWM_BURST_RETRIG_EN
      // Restart after 5 ticks of a 4x3 burst; only the restarted burst completes.
      @(posedge i_sclk); #1;
      i_period = CNT_W'(4);
      i_duty   = CNT_W'(1);
      i_num    = NUM_W'(3);
      i_sen    = 1'b1;
      exp_q.push_back(predict(4, 1, 12));
      @(posedge i_sclk); #1;
      i_sen = 1'b0;
      i_ena = 1'b1;
      repeat (5) @(posedge i_sclk);
      #1;
      i_ena = 1'b0;
      i_sen = 1'b1;
      @(posedge i_sclk); #1;
      i_sen = 1'b0;
      i_ena = 1'b1;
      repeat (12) @(posedge i_sclk);
      #1;
      i_ena = 1'b0;
      repeat (3) @(posedge i_sclk);
      #1;
`endif

      for (int n = 0; n < 40; n++) begin
         per      = $urandom_range(0, 6);
         duty     = $urandom_range(0, 7);
         num      = $urandom_range(0, 4);
         abort_at = -1;
         fin      = 1'b0;
         if (per * num > 0 && $urandom_range(0, 3) == 0) begin
            abort_at = $urandom_range(0, per * num - 1);
            fin      = (abort_at == per * num - 1) && ($urandom_range(0, 1) == 1);
         end
         run_burst(per, duty, num, $urandom_range(0, 2), abort_at, fin,
                   SenInRun && ($urandom_range(0, 1) == 1));
      end

      repeat (3) @(posedge i_sclk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_burst_gen.md
Name: pwm_burst_gen

Overview:
- Slave-clock-domain PWM burst engine; sits directly downstream of the master-to-slave enable synchronizer.
- Consumes the synchronizer's single-cycle slave-enable pulse as its start trigger.
- On start it latches period, duty and pulse count, then emits a burst of PWM periods gated by the slave tick enable.
- Flags completion with a one-cycle done pulse, which feeds the synchronizer's acknowledge path back to the master domain.

Parameters:
- CNT_W, 16: width of the period/duty counter and configuration inputs.
- NUM_W, 8: width of the pulse-count configuration and pulse counter.

Ports:
- i_sclk  input  1  slave clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_ena  input  1  tick enable; counters advance only on edges with i_ena=1.
- i_sen  input  1  start pulse, one i_sclk cycle wide (synchronizer o_sen).
- i_abort  input  1  synchronous abort request.
- i_period  input  CNT_W  PWM period in ticks; sampled on accepted start.
- i_duty  input  CNT_W  high time in ticks; sampled on accepted start.
- i_num  input  NUM_W  number of PWM periods in the burst; sampled on accepted start.
- o_pwm  output  1  PWM waveform.
- o_busy  output  1  high while state is RUN.
- o_done  output  1  one-cycle completion pulse.
- o_cnt  output  NUM_W  completed periods in the current or last burst.

Behaviour:
- Clock/reset: one clock, i_sclk. Asynchronous active-low reset i_rst_n.
- Reset: state=IDLE; tick counter, period_q, duty_q, num_q and o_cnt all 0. o_pwm=0, o_busy=0, o_done=0.
- Reset asserted mid-burst returns to this state immediately. No done pulse is generated.

States:
- IDLE -> RUN: on i_sen=1 with (i_period!=0 and i_num!=0). Latch period_q/duty_q/num_q. Clear the tick counter and o_cnt. i_ena is not required.
- IDLE -> DONE: on i_sen=1 with (i_period==0 or i_num==0). Zero-length burst; o_pwm never rises. Config latched but unused.
- RUN, edge with i_ena=1 and tick counter < period_q-1: tick counter +1.
- RUN, edge with i_ena=1 and tick counter == period_q-1:
  - Tick counter wraps to 0 and o_cnt +1.
  - If o_cnt+1 == num_q, go to DONE.
- RUN, edge with i_ena=0: hold all state.
- RUN, i_abort=1: go to DONE on that edge, regardless of i_ena. o_cnt holds its current value (not incremented).
- DONE: lasts exactly one cycle with o_done=1, then returns to IDLE.

Outputs:
- o_pwm = (state==RUN) & (tick counter < duty_q). Decoded from registers only; no combinational path from any input.
- Duty edge cases: duty_q=0 gives constant low; duty_q >= period_q gives constant high for the whole burst.
- o_busy = (state==RUN).
- Burst length: exactly period_q*num_q i_ena ticks. The first tick counts from the cycle after start.

Simultaneous events and boundaries:
- i_sen while in RUN or DONE: ignored (base build). Configuration inputs may change freely outside the start cycle.
- i_abort and i_sen in the same IDLE cycle: start wins; abort is only honoured in RUN.
- i_abort and the final-wrap condition on the same edge: go to DONE with o_cnt incremented, i.e. the completion is counted.
- Counter arithmetic is unsigned. o_cnt saturates naturally at num_q because the burst terminates; it never wraps.

Optional Feature:
- Macro: PWM_BURST_RETRIG_EN.
- Defined: i_sen=1 in RUN restarts the burst on that edge.
  - Re-latch config; tick counter=0, o_cnt=0.
  - If the new i_period or i_num is 0, go to DONE.
  - No o_done for the truncated burst.
  - i_abort has priority over retrigger.
- Not defined: i_sen outside IDLE is ignored, as described in Behaviour.

Test Plan:
- i_ena=1; i_period=4, i_duty=1, i_num=3; pulse i_sen:
  - o_busy high for 12 cycles.
  - o_pwm pattern 1000 1000 1000.
  - o_cnt steps 1, 2, 3.
  - o_done pulses once, in the cycle after o_busy falls.
- i_ena high every 2nd cycle; period=3, duty=2, num=2:
  - o_pwm high 4 cycles, low 2 cycles, repeated twice (12 cycles total).
  - Counters frozen on i_ena=0 cycles.
- Edge configurations:
  - duty=0 gives o_pwm=0 throughout.
  - duty=5 with period=4 gives o_pwm=1 for all 4*num ticks.
  - period=0 or num=0 gives o_done one cycle after i_sen, with o_busy and o_pwm never asserted.
- period=8, num=4; i_abort at tick 13:
  - Next cycle o_pwm=0, o_busy=0, o_done=1, o_cnt=1.
  - i_sen during RUN with the macro undefined has no effect.
- i_rst_n driven low mid-burst (asynchronous, between edges):
  - Outputs go to 0 immediately; no o_done.
  - After release, a new i_sen starts a clean burst.
- With PWM_BURST_RETRIG_EN defined:
  - i_sen at tick 5 of a period=4, num=3 burst restarts it with o_cnt=0.
  - The total burst is 5+12 ticks, followed by a single o_done.
